// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and helpers for the mips run controller: FSM state encoding and
// a counter-width helper used by the controller and its PC stability detector.
package run_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } run_state_e;

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bus between the run controller (slave) and the core/bench side (master):
// restart request and observed PC in, core reset and run status out.
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             restart_i;
    logic [PC_W-1:0]  pc_i;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output restart_i, pc_i,
        input  cpu_reset, running, done, timeout, cycle_count
    );

    modport slave (
        input  restart_i, pc_i,
        output cpu_reset, running, done, timeout, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl_pc_stable_det.sv
// Detects a parked core: raises stable_hit in the cycle whose PC compare brings
// the run of consecutive equal-PC compares up to HALT_STABLE.
module pc_stable_det
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int HALT_STABLE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc_i,
    output logic            stable_hit
);

    localparam int            SC_W      = cnt_w(HALT_STABLE);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(HALT_STABLE);
    localparam bit            STABLE_EN = (HALT_STABLE != 0);

    logic [PC_W-1:0] pc_q_r;
    logic            pc_vld_r;
    logic [SC_W-1:0] stable_cnt_r;
    logic            same_s;
    logic [SC_W-1:0] stable_nxt_s;

    // Compare against the previous PC and form the saturating next count.
    always_comb begin
        same_s       = 1'b0;
        stable_nxt_s = '0;
        stable_hit   = 1'b0;
        if (pc_vld_r && (pc_i == pc_q_r)) begin
            same_s = 1'b1;
        end else begin
            same_s = 1'b0;
        end
        if (same_s) begin
            if (stable_cnt_r == SC_MAX) begin
                stable_nxt_s = SC_MAX;
            end else begin
                stable_nxt_s = stable_cnt_r + 1'b1;
            end
        end else begin
            stable_nxt_s = '0;
        end
        if (STABLE_EN && en && same_s && (stable_nxt_s == SC_MAX)) begin
            stable_hit = 1'b1;
        end else begin
            stable_hit = 1'b0;
        end
    end

    // PC history register; pc_vld_r suppresses the compare in the first RUN cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pc_q_r       <= '0;
            pc_vld_r     <= 1'b0;
            stable_cnt_r <= '0;
        end else if (en) begin
            pc_q_r       <= pc_i;
            pc_vld_r     <= 1'b1;
            stable_cnt_r <= stable_nxt_s;
        end else begin
            pc_q_r       <= pc_q_r;
            pc_vld_r     <= pc_vld_r;
            stable_cnt_r <= stable_cnt_r;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined mips core: issues the core reset pulse,
// counts RUN cycles and ends the run on a halt PC, a parked PC or the watchdog.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              RESET_CYCLES = 10,
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HALT_PC      = 32'h0000_3ffc,
    parameter bit              HALT_PC_EN   = 1'b1,
    parameter int              HALT_STABLE  = 4,
    parameter int              CNT_W        = 32,
    parameter int              MAX_CYCLES   = 10000
) (
    input  logic         clk,
    input  logic         reset,
    cpu_run_ctrl_if.slave bus
);

    localparam int               RC_W    = cnt_w(RESET_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

    if (RESET_CYCLES < 1) begin : g_chk_reset_cycles
        $error("cpu_run_ctrl: RESET_CYCLES must be at least 1");
    end
    if ((CNT_W < 32) && ((MAX_CYCLES >> CNT_W) != 0)) begin : g_chk_max_cycles
        $error("cpu_run_ctrl: MAX_CYCLES does not fit in CNT_W bits");
    end

    run_state_e       state_r;
    run_state_e       state_nxt_s;
    logic [RC_W-1:0]  rst_cnt_r;
    logic [RC_W-1:0]  rst_cnt_nxt_s;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             timeout_r;
    logic             tmo_nxt_s;
    logic             cpu_reset_r;
    logic             running_r;
    logic             halt_s;
    logic             stable_hit_s;
    logic             det_clr_s;
    logic             det_en_s;

    assign det_en_s  = (state_r == ST_RUN);
    assign det_clr_s = (state_r != ST_RUN) || bus.restart_i;

    pc_stable_det #(
        .PC_W        (PC_W),
        .HALT_STABLE (HALT_STABLE)
    ) u_stable (
        .clk        (clk),
        .reset      (reset),
        .clr        (det_clr_s),
        .en         (det_en_s),
        .pc_i       (bus.pc_i),
        .stable_hit (stable_hit_s)
    );

    // Next state, counters and sticky flags; restart_i overrides every state.
    always_comb begin
        state_nxt_s   = state_r;
        rst_cnt_nxt_s = rst_cnt_r;
        cnt_nxt_s     = cycle_count_r;
        cnt_inc_s     = cycle_count_r + 1'b1;
        done_nxt_s    = done_r;
        tmo_nxt_s     = timeout_r;
        halt_s        = 1'b0;
        if ((HALT_PC_EN && (bus.pc_i == HALT_PC)) || stable_hit_s) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
        if (bus.restart_i) begin
            state_nxt_s   = ST_RST;
            rst_cnt_nxt_s = '0;
            cnt_nxt_s     = '0;
            done_nxt_s    = 1'b0;
            tmo_nxt_s     = 1'b0;
        end else begin
            case (state_r)
                ST_RST: begin
                    if (rst_cnt_r == RC_LAST) begin
                        state_nxt_s   = ST_RUN;
                        rst_cnt_nxt_s = '0;
                    end else begin
                        rst_cnt_nxt_s = rst_cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_nxt_s = cnt_inc_s;
                    // A halt seen on the watchdog's last cycle still ends as DONE.
                    if (halt_s) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else if (cnt_inc_s == CNT_MAX) begin
                        state_nxt_s = ST_TMO;
                        tmo_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE, ST_TMO: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s   = ST_RST;
                    rst_cnt_nxt_s = '0;
                    cnt_nxt_s     = '0;
                    done_nxt_s    = 1'b0;
                    tmo_nxt_s     = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_r     <= '0;
            cycle_count_r <= '0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            cpu_reset_r   <= 1'b1;
            running_r     <= 1'b0;
        end else begin
            rst_cnt_r     <= rst_cnt_nxt_s;
            cycle_count_r <= cnt_nxt_s;
            done_r        <= done_nxt_s;
            timeout_r     <= tmo_nxt_s;
            cpu_reset_r   <= (state_nxt_s != ST_RUN);
            running_r     <= (state_nxt_s == ST_RUN);
        end
    end

    assign bus.cpu_reset   = cpu_reset_r;
    assign bus.running     = running_r;
    assign bus.done        = done_r;
    assign bus.timeout     = timeout_r;
    assign bus.cycle_count = cycle_count_r;

endmodule
